// File: rtl/ysyx_22050710_pkg.sv
// Shared constants and bus layouts for the ysyx_22050710 fetch stage.
package ysyx_22050710_pkg;

    localparam int          INST_WD_DEF         = 32;
    localparam int          PC_WD_DEF           = 64;
    localparam logic [63:0] PC_RESETVAL_DEF     = 64'h8000_0000;
    localparam int          IBUF_DEPTH_DEF      = 4;
    localparam int          MAX_OUTSTANDING_DEF = 2;

    // Branch bus is {stall, taken, target}; taken/stall offsets are relative to PC_WD.
    localparam int BR_TARGET_LSB = 0;
    localparam int BR_TAKEN_OFS  = 0;
    localparam int BR_STALL_OFS  = 1;

    // Wrong-path responses still owed by the SRAM can pile up across back-to-back
    // branches against a slow memory, so the discard counter is kept generously wide.
    localparam int DISCARD_WD = 8;

    // Decode-side bus for the default widths, packed {inst, pc}.
    typedef struct packed {
        logic [INST_WD_DEF-1:0] inst;
        logic [PC_WD_DEF-1:0]   pc;
    } fs_to_ds_t;

endpackage

// File: rtl/ysyx_22050710_ibuf.sv
// In-order instruction ring buffer: entries are allocated at issue (pc known),
// filled when the SRAM responds, and dequeued to decode from the head.
module ysyx_22050710_ibuf #(
    parameter int DEPTH   = 4,
    parameter int PC_WD   = 64,
    parameter int INST_WD = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   alloc,
    input  logic [PC_WD-1:0]       alloc_pc,
    input  logic                   fill_en,
    input  logic [INST_WD-1:0]     fill_inst,
    input  logic                   deq,
    output logic [$clog2(DEPTH):0] count,
    output logic                   fill_hi,
    output logic                   fill_at_head,
    output logic                   head_filled,
    output logic [PC_WD-1:0]       head_pc,
    output logic [INST_WD-1:0]     head_inst
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]      head;
    logic [PW-1:0]      fill;
    logic [PW-1:0]      tail;
    logic [DEPTH-1:0]   filled;
    logic [PC_WD-1:0]   pc_q   [DEPTH];
    logic [INST_WD-1:0] inst_q [DEPTH];

    // Pointers, occupancy and per-entry filled flags; a flush empties the ring.
    // When a bypassed response fills and dequeues the head together, the
    // dequeue clear is written last so the entry ends up empty.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head   <= '0;
            fill   <= '0;
            tail   <= '0;
            count  <= '0;
            filled <= '0;
        end else begin
            if (alloc) begin
                tail         <= tail + PW'(1);
                filled[tail] <= 1'b0;
            end
            if (fill_en) begin
                fill         <= fill + PW'(1);
                filled[fill] <= 1'b1;
            end
            if (deq) begin
                head         <= head + PW'(1);
                filled[head] <= 1'b0;
            end
            count <= count + CW'(alloc) - CW'(deq);
        end
    end

    // Entry payload: pc captured at issue, instruction captured at response.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                inst_q[i] <= '0;
            end
        end else begin
            if (alloc) begin
                pc_q[tail] <= alloc_pc;
            end
            if (fill_en) begin
                inst_q[fill] <= fill_inst;
            end
        end
    end

    assign fill_hi      = pc_q[fill][2];
    assign fill_at_head = (fill == head);
    assign head_filled  = filled[head];
    assign head_pc      = pc_q[head];
    assign head_inst    = inst_q[head];

endmodule

// File: rtl/ysyx_22050710_fetch_unit.sv
// Instruction fetch stage with split-transaction SRAM port, bounded in-flight
// requests and an in-order instruction buffer. Taken branches squash wrong-path
// requests, responses and buffered instructions.
// Optional response-to-decode bypass: define YSYX_22050710_IBUF_BYPASS_EN.
module ysyx_22050710_fetch_unit
    import ysyx_22050710_pkg::*;
#(
    parameter int               INST_WD         = INST_WD_DEF,
    parameter int               PC_WD           = PC_WD_DEF,
    parameter logic [PC_WD-1:0] PC_RESETVAL     = PC_WD'(PC_RESETVAL_DEF),
    parameter int               FS_TO_DS_BUS_WD = INST_WD + PC_WD,
    parameter int               BR_BUS_WD       = PC_WD + 2,
    parameter int               SRAM_ADDR_WD    = 64,
    parameter int               SRAM_DATA_WD    = 64,
    parameter int               IBUF_DEPTH      = IBUF_DEPTH_DEF,
    parameter int               MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_ds_allowin,
    input  logic [BR_BUS_WD-1:0]       i_br_bus,
    output logic                       o_fs_to_ds_valid,
    output logic [FS_TO_DS_BUS_WD-1:0] o_fs_to_ds_bus,
    output logic                       o_inst_sram_req,
    output logic [SRAM_ADDR_WD-1:0]    o_inst_sram_addr,
    input  logic                       i_inst_sram_addr_ok,
    input  logic                       i_inst_sram_data_ok,
    input  logic [SRAM_DATA_WD-1:0]    i_inst_sram_rdata
);

    localparam int CW = $clog2(IBUF_DEPTH) + 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

`ifdef YSYX_22050710_IBUF_BYPASS_EN
    localparam bit BYPASS_EN = 1'b1;
`else
    localparam bit BYPASS_EN = 1'b0;
`endif

    logic                  br_stall;
    logic                  br_taken;
    logic [PC_WD-1:0]      br_target;
    logic [PC_WD-1:0]      fpc;
    logic [OW-1:0]         outstanding;
    logic [DISCARD_WD-1:0] discard;
    logic [CW-1:0]         count;
    logic                  handshake;
    logic                  resp_fill;
    logic                  bypass;
    logic                  deq;
    logic                  fill_hi;
    logic                  fill_at_head;
    logic                  head_filled;
    logic [PC_WD-1:0]      head_pc;
    logic [INST_WD-1:0]    head_inst;
    logic [INST_WD-1:0]    fill_inst;
    logic [INST_WD-1:0]    out_inst;

    assign br_target = i_br_bus[BR_TARGET_LSB +: PC_WD];
    assign br_taken  = i_br_bus[PC_WD + BR_TAKEN_OFS];
    assign br_stall  = i_br_bus[PC_WD + BR_STALL_OFS];

    // Every in-flight request already owns a buffer entry, so gating on
    // occupancy alone is enough to make overflow impossible.
    assign o_inst_sram_req  = ~i_rst & ~br_stall & ~br_taken
                            & (outstanding < OW'(MAX_OUTSTANDING))
                            & (count < CW'(IBUF_DEPTH));
    assign o_inst_sram_addr = SRAM_ADDR_WD'(fpc);

    assign handshake = o_inst_sram_req & i_inst_sram_addr_ok;
    assign resp_fill = i_inst_sram_data_ok & ~i_rst & ~br_taken & (discard == '0);

    // A 64-bit beat holds two instructions; pc[2] picks the half.
    assign fill_inst = fill_hi ? i_inst_sram_rdata[2*INST_WD-1:INST_WD]
                               : i_inst_sram_rdata[INST_WD-1:0];

    assign bypass           = BYPASS_EN & resp_fill & fill_at_head;
    assign o_fs_to_ds_valid = ~i_rst & ~br_taken & (head_filled | bypass);
    assign out_inst         = bypass ? fill_inst : head_inst;
    assign o_fs_to_ds_bus   = {out_inst, head_pc};
    assign deq              = o_fs_to_ds_valid & i_ds_allowin;

    // Issue PC: redirect on branch, otherwise advance one instruction per handshake.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fpc <= PC_RESETVAL;
        end else if (br_taken) begin
            fpc <= br_target;
        end else if (handshake) begin
            fpc <= fpc + PC_WD'(4);
        end
    end

    // In-flight bookkeeping: on a branch all live requests become owed-and-dropped
    // responses, less any response that arrives (and is dropped) in that same cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            outstanding <= '0;
            discard     <= '0;
        end else if (br_taken) begin
            outstanding <= '0;
            discard     <= discard + DISCARD_WD'(outstanding)
                         - DISCARD_WD'(i_inst_sram_data_ok);
        end else begin
            outstanding <= outstanding + OW'(handshake) - OW'(resp_fill);
            if (i_inst_sram_data_ok && (discard != '0)) begin
                discard <= discard - DISCARD_WD'(1);
            end
        end
    end

    ysyx_22050710_ibuf #(
        .DEPTH   (IBUF_DEPTH),
        .PC_WD   (PC_WD),
        .INST_WD (INST_WD)
    ) u_ibuf (
        .clk          (i_clk),
        .rst          (i_rst),
        .flush        (br_taken),
        .alloc        (handshake),
        .alloc_pc     (fpc),
        .fill_en      (resp_fill),
        .fill_inst    (fill_inst),
        .deq          (deq),
        .count        (count),
        .fill_hi      (fill_hi),
        .fill_at_head (fill_at_head),
        .head_filled  (head_filled),
        .head_pc      (head_pc),
        .head_inst    (head_inst)
    );

endmodule
